player_health_ctrl: RTL and testbench

//  Per-player health bookkeeping, one stage upstream of the OLED health bar.

---
 rtl/player_health_ctrl_pkg.sv | 24 ++
 rtl/player_health_ctrl_tick_divider.sv | 28 ++
 rtl/player_health_ctrl.sv | 119 +++++++++++
 tb/tb_player_health_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/player_health_ctrl_pkg.sv
// Shared definitions for the player health controller: widths, default sizing,
// FSM state encoding and the saturating health subtraction.
package player_health_ctrl_pkg;

    localparam int HEALTH_W        = 9;
    localparam int FULL_HEALTH_DEF = 200;
    localparam int DMG_W_DEF       = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_IFRAME = 2'd2,
        ST_KO     = 2'd3
    } state_t;

    // Health never wraps: a hit larger than the remaining health lands on 0.
    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] health,
        input logic [HEALTH_W-1:0] dmg
    );
        return (health > dmg) ? health - dmg : '0;
    endfunction

endpackage

// File: rtl/player_health_ctrl_tick_divider.sv
// Free-running divider producing a registered one-cycle tick every DIV cycles.
// Reused for any animation rate; only reset clears it.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/player_health_ctrl.sv
// Per-player health bookkeeping ahead of the OLED health bar: hit acceptance,
// block reduction, invincibility frames, KO detection and the bar's drain tick.
module player_health_ctrl
    import player_health_ctrl_pkg::*;
#(
    parameter int FULL_HEALTH   = FULL_HEALTH_DEF,
    parameter int DMG_W         = DMG_W_DEF,
    parameter int BLOCK_SHIFT   = 2,
    parameter int IFRAME_CYCLES = 25,
    parameter int DRAIN_DIV     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                round_start,
    input  logic                hit_valid,
    input  logic [DMG_W-1:0]    hit_damage,
    input  logic                hit_blocked,
    output logic                hit_ready,
    output logic [HEALTH_W-1:0] curr_health,
    output logic                ko,
    output logic                invincible,
    output logic [7:0]          hits_taken,
    output logic                drain_tick
);

    localparam int IFR_W = $clog2(IFRAME_CYCLES + 1);

    state_t              state, state_nx;
    logic [HEALTH_W-1:0] health_nx;
    logic [7:0]          hits_nx;
    logic [IFR_W-1:0]    ifr_cnt, ifr_nx;

    logic [DMG_W-1:0]    dmg_shifted;
    logic [DMG_W-1:0]    eff;
    logic [HEALTH_W-1:0] eff_ext;
    logic [HEALTH_W-1:0] health_hit;
    logic                hit_accept;

    // Blocking scales damage down but a nonzero hit always costs at least 1.
    assign dmg_shifted = hit_damage >> BLOCK_SHIFT;
    always_comb begin
        eff = '0;
        if (hit_damage != '0) begin
            if (!hit_blocked)
                eff = hit_damage;
            else if (dmg_shifted == '0)
                eff = DMG_W'(1);
            else
                eff = dmg_shifted;
        end
    end

    assign eff_ext    = HEALTH_W'(eff);
    assign health_hit = sat_sub(curr_health, eff_ext);
    assign hit_ready  = (state == ST_ACTIVE) && !round_start;
    assign hit_accept = hit_valid && hit_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            curr_health <= HEALTH_W'(FULL_HEALTH);
            hits_taken  <= '0;
            ifr_cnt     <= '0;
        end else begin
            state       <= state_nx;
            curr_health <= health_nx;
            hits_taken  <= hits_nx;
            ifr_cnt     <= ifr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        health_nx = curr_health;
        hits_nx   = hits_taken;
        ifr_nx    = ifr_cnt;
        if (round_start) begin
            state_nx  = ST_ACTIVE;
            health_nx = HEALTH_W'(FULL_HEALTH);
            hits_nx   = '0;
            ifr_nx    = '0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    // Zero-damage hits are consumed without side effects.
                    if (hit_accept && eff != '0) begin
                        health_nx = health_hit;
                        hits_nx   = (hits_taken == 8'hFF) ? hits_taken : hits_taken + 8'd1;
                        if (health_hit == '0) begin
                            state_nx = ST_KO;
                        end else begin
                            state_nx = ST_IFRAME;
                            ifr_nx   = IFR_W'(IFRAME_CYCLES - 1);
                        end
                    end
                end
                ST_IFRAME: begin
                    if (ifr_cnt == '0)
                        state_nx = ST_ACTIVE;
                    else
                        ifr_nx = ifr_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ko         = (state == ST_KO);
    assign invincible = (state == ST_IFRAME);

    tick_divider #(
        .DIV (DRAIN_DIV)
    ) u_drain_div (
        .clk   (clk),
        .reset (reset),
        .tick  (drain_tick)
    );

endmodule

// File: tb/tb_player_health_ctrl.sv
// Scoreboard bench for player_health_ctrl: a cycle-level reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares them.
module tb_player_health_ctrl;

    localparam int FULL   = 200;
    localparam int BSHIFT = 2;
    localparam int IFR    = 25;
    localparam int DDIV   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       round_start = 1'b0;
    logic       hit_valid = 1'b0;
    logic [5:0] hit_damage = '0;
    logic       hit_blocked = 1'b0;
    logic       hit_ready;
    logic [8:0] curr_health;
    logic       ko;
    logic       invincible;
    logic [7:0] hits_taken;
    logic       drain_tick;

    player_health_ctrl #(
        .FULL_HEALTH(FULL), .DMG_W(6), .BLOCK_SHIFT(BSHIFT),
        .IFRAME_CYCLES(IFR), .DRAIN_DIV(DDIV)
    ) dut (
        .clk(clk), .reset(reset), .round_start(round_start),
        .hit_valid(hit_valid), .hit_damage(hit_damage), .hit_blocked(hit_blocked),
        .hit_ready(hit_ready), .curr_health(curr_health), .ko(ko),
        .invincible(invincible), .hits_taken(hits_taken), .drain_tick(drain_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk_rdy;
        logic       rdy;
        logic [8:0] health;
        logic       ko;
        logic       inv;
        logic [7:0] hits;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: health points, hit count, remaining invincible cycles,
    // round/KO flags and cycles elapsed since reset.
    int m_h, m_hits, m_ifl, m_n;
    bit m_round, m_ko, m_known;

    function automatic int eff_of(int d, bit b);
        int s;
        if (d == 0) return 0;
        if (!b) return d;
        s = d / (1 << BSHIFT);
        return (s < 1) ? 1 : s;
    endfunction

    task automatic chk(string name, logic [8:0] act, logic [8:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit rs, input bit hv,
                       input int d, input bit b, output bit acc);
        exp_t e;
        bit   ready;
        int   eff;
        @(negedge clk);
        reset = r; round_start = rs; hit_valid = hv;
        hit_damage = 6'(d); hit_blocked = b;
        ready = m_round && !m_ko && (m_ifl == 0) && !rs;
        e.chk_rdy = m_known;
        e.rdy = ready;
        acc = 1'b0;
        if (r) begin
            m_h = FULL; m_hits = 0; m_ifl = 0; m_n = 0;
            m_round = 0; m_ko = 0; m_known = 1;
        end else begin
            m_n++;
            if (rs) begin
                m_h = FULL; m_hits = 0; m_ifl = 0; m_round = 1; m_ko = 0;
            end else if (hv && ready) begin
                acc = 1'b1;
                eff = eff_of(d, b);
                if (eff > 0) begin
                    m_h = (m_h > eff) ? m_h - eff : 0;
                    m_hits = (m_hits < 255) ? m_hits + 1 : 255;
                    if (m_h == 0) m_ko = 1;
                    else m_ifl = IFR;
                end
            end else if (m_ifl > 0) begin
                m_ifl--;
            end
        end
        e.health = 9'(m_h);
        e.ko     = m_ko;
        e.inv    = (m_ifl > 0);
        e.hits   = 8'(m_hits);
        e.tick   = (m_n > 0) && (m_n % DDIV == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, acc);
    endtask

    // Hold an offered hit stable until accepted, within a bounded wait.
    task automatic offer(int d, bit b);
        bit acc = 0;
        for (int i = 0; i < 100 && !acc; i++) cyc(0, 0, 1, d, b, acc);
        if (!acc) begin
            tests++; fails++;
            $display("FAIL offer_timeout: got not-accepted expected accepted (dmg %0d)", d);
        end
        idle(1);
    endtask

    // Monitor: hit_ready checked mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_rdy) chk("hit_ready", 9'(hit_ready), 9'(e.rdy));
                @(posedge clk);
                #1;
                chk("curr_health", curr_health, e.health);
                chk("ko", 9'(ko), 9'(e.ko));
                chk("invincible", 9'(invincible), 9'(e.inv));
                chk("hits_taken", 9'(hits_taken), 9'(e.hits));
                chk("drain_tick", 9'(drain_tick), 9'(e.tick));
            end
        end
    end

    initial begin
        bit acc;
        bit p_valid = 0, p_blk = 0;
        int p_dmg = 0;
        m_known = 0; m_h = 0; m_hits = 0; m_ifl = 0; m_n = 0; m_round = 0; m_ko = 0;

        // Reset, round start, drain cadence
        cyc(1, 0, 0, 0, 0, acc);
        cyc(1, 0, 0, 0, 0, acc);
        idle(3);
        cyc(0, 1, 0, 0, 0, acc);
        idle(6);
        // Unblocked 30, then a hit held through IFRAME
        offer(30, 0);
        offer(10, 0);
        idle(30);
        // Blocked hits after a fresh round
        cyc(0, 1, 0, 0, 0, acc);
        offer(20, 1);
        idle(30);
        offer(2, 1);
        offer(0, 0);
        idle(30);
        // Drive to 10 health, then overkill without wrap, then hits in KO
        cyc(0, 1, 0, 0, 0, acc);
        offer(63, 0); offer(63, 0); offer(63, 0); offer(1, 0);
        offer(63, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 40, 0, acc);
        // round_start with a same-cycle hit
        cyc(0, 1, 1, 40, 0, acc);
        idle(3);
        // Reset mid-IFRAME
        offer(30, 0);
        idle(5);
        cyc(1, 0, 0, 0, 0, acc);
        idle(10);

        // Randomized traffic with stable held hits
        for (int i = 0; i < 4000; i++) begin
            bit r, rs;
            r  = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 59) == 0);
            if (!p_valid && $urandom_range(0, 2) == 0) begin
                p_valid = 1;
                p_dmg   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
                p_blk   = $urandom_range(0, 1);
            end
            cyc(r, rs, p_valid, p_dmg, p_blk, acc);
            if (acc) p_valid = 0;
        end
        idle(2);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
